// File: rtl/comparator_serial_n_bit.sv
// Bit-serial WIDTH-bit magnitude comparator: operands arrive MSB first, one pair
// per valid/ready transfer, and a registered one-hot e/g/l result is strobed by done.
module comparator_serial_n_bit #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic a_bit,
  input  logic b_bit,
  input  logic bit_valid,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic e,
  output logic g,
  output logic l
);

  // A one-bit counter is still needed when WIDTH is 1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             decided_q;
  logic             gt_q;
  logic             lt_q;
  logic             e_q;
  logic             g_q;
  logic             l_q;

  logic             accept;
  logic             last_pair;
  logic             decided_d;
  logic             gt_d;
  logic             lt_d;

  // Handshake outputs decode from state alone, so no input reaches an output
  // combinationally.
  assign bit_ready = (state_q == S_SHIFT);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign e         = e_q;
  assign g         = g_q;
  assign l         = l_q;

  assign accept    = bit_valid & bit_ready;
  assign last_pair = (cnt_q == LAST_CNT);

  // The first differing pair from the MSB fixes gt/lt; later pairs are only counted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it
    // unassigned and infer a latch.
    decided_d = decided_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    if (accept && !decided_q && (a_bit != b_bit)) begin
      decided_d = 1'b1;
      gt_d      = a_bit & ~b_bit;
      lt_d      = ~a_bit & b_bit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      e_q       <= 1'b0;
      g_q       <= 1'b0;
      l_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_SHIFT;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            e_q       <= 1'b0;
            g_q       <= 1'b0;
            l_q       <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (accept) begin
            cnt_q     <= cnt_q + CNT_W'(1);
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            if (last_pair) begin
              // Result is loaded on the way into DONE so it is valid alongside done.
              state_q <= S_DONE;
              e_q     <= ~(gt_d | lt_d);
              g_q     <= gt_d;
              l_q     <= lt_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/comparator_serial_n_bit.md
# comparator_serial_n_bit

Bit-serial WIDTH-bit magnitude comparator. After a start pulse it takes two operands one bit pair per transfer, most-significant bit first, over a valid/ready handshake. It returns a registered one-hot equal/greater/less result with a single-cycle done strobe. It cascades the single-bit compare (XNOR for equal, a&~b for greater, ~a&b for less) across time, so wide operands arriving on serial links need no parallel comparator tree.

## Interface
- WIDTH, 8: operand length in bits; legal range 1..32.
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a comparison; sampled only in IDLE.
- a_bit  input  1  current bit of operand A, MSB first.
- b_bit  input  1  current bit of operand B, MSB first.
- bit_valid  input  1  a_bit/b_bit hold a valid pair.
- bit_ready  output  1  block accepts a pair this cycle.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle strobe; result valid.
- e  output  1  A == B.
- g  output  1  A > B.
- l  output  1  A < B.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE. The state register is encoded in 2 bits.
- A pair is accepted on any cycle where bit_valid & bit_ready is high.
- IDLE:
  - bit_ready=0, busy=0, done=0.
  - When start=1, go to SHIFT. Clear the bit counter, the decided flag, and the internal gt/lt flags. Clear e, g and l to 0.
- SHIFT:
  - bit_ready=1, busy=1.
  - If no pair is accepted, hold state and all registers. bit_valid may drop on any cycle.
  - On an accepted pair with decided=0 and a_bit!=b_bit, set decided=1, gt=a_bit&~b_bit and lt=~a_bit&b_bit.
  - Once decided=1, later pairs are consumed but cannot change gt/lt. The first differing bit from the MSB fixes the result.
  - The counter increments on every accepted pair. On the accept where counter==WIDTH-1, go to DONE.
  - The counter needs at least 1 bit, even for WIDTH=1.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, bit_ready=0.
  - e, g and l are loaded on the transition into DONE, so they are already valid while done=1: e=~(gt|lt), g=gt, l=lt.
  - Always returns to IDLE on the next cycle.
- Once loaded, e/g/l hold their values through IDLE until the next accepted start clears them.
- start is ignored in SHIFT and DONE. No queuing: a start in DONE is lost.
- a_bit/b_bit are ignored whenever bit_ready=0.
- If rst_n is asserted mid-operation, everything returns immediately to the reset state below. The partial comparison is discarded and done never fires.

## Timing
- Reset values: state=IDLE, bit_ready=0, busy=0, done=0, e=0, g=0, l=0, counter=0, decided=0.
- Cycle of start (cycle 0) has IDLE outputs; SHIFT begins cycle 1 with bit_ready=1.
- With bit_valid held high, pairs are accepted on cycles 1..WIDTH. done=1 with the final result on cycle WIDTH+1, and the block is in IDLE on cycle WIDTH+2.
- Each cycle that bit_valid is low in SHIFT extends the latency by one cycle.
- Minimum start-to-start spacing is WIDTH+2 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, A=0xA5, B=0xA5, start at cycle 0, bit_valid held high -> done=1 on cycle 9 with e=1, g=0, l=0; IDLE on cycle 10.
- A=0x80, B=0x7F, where the MSB differs and the remaining 7 bits are reversed -> done on cycle 9 with g=1, e=0, l=0. Later bits must not flip the result.
- A=0x12, B=0x13, where only the LSB differs; bit_valid is low for 3 random cycles mid-stream -> done on cycle 12 with l=1. bit_ready stays 1 throughout SHIFT.
- Start pulses issued on cycles 4 (SHIFT) and 9 (DONE) during an A=0x00, B=0x00 run -> both ignored. Exactly one done fires, with e=1, then the block is in IDLE. e stays 1 until the next accepted start, which clears it on the following cycle.
- Assert rst_n low after 5 pairs of A=0xF0, B=0x0F, then release -> all outputs are 0 immediately and done never fires. A fresh start with A=0x01, B=0x02 gives l=1 on cycle 9.
- WIDTH=1, pairs (1,0), (0,1), (1,1) in separate runs -> done on cycle 2 with g=1, then l=1, then e=1.
